lii_unpack_router: RTL and testbench

//  Successor to the single-stream LII input unpacker. Takes one LII phy input channel and routes

---
 rtl/lii_unpack_router.sv | 92 +++++++++
 tb/tb_lii_unpack_router.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lii_unpack_router.sv
// lii_unpack_router: routes LII beats by dst into per-channel FIFOs and serialises them into kernel words
module lii_unpack_router #(
  parameter int NCH      = 2,
  parameter int PW       = 64,
  parameter int KW       = 8,
  parameter int LANES    = 1,
  parameter int DEPTH    = 4,
  parameter int BASE_DST = 0
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic [PW-1:0]     lii_in_p0_tdata,
  input  logic              lii_in_p0_tvalid,
  output logic              lii_in_p0_tready,
  input  logic [7:0]        lii_in_p0_src,
  input  logic [7:0]        lii_in_p0_dst,
  output logic [NCH*KW-1:0] ch_tdata,
  output logic [NCH-1:0]    ch_tvalid,
  input  logic [NCH-1:0]    ch_tready,
  output logic [15:0]       drop_cnt,
  output logic              ce
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = LANES * KW;
  localparam int CW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic [7:0] BASE = 8'(BASE_DST);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);
  logic [7:0]     idx;
  logic [NCH-1:0] hit, full, full_n;
  logic           route_ok;
  logic [15:0]    drop_q, drop_d;
  logic           ce_q;
  logic           unused_bits;
  assign unused_bits = ^{lii_in_p0_src, lii_in_p0_tdata};
  assign idx = lii_in_p0_dst - BASE;
  assign route_ok = |hit;
  assign lii_in_p0_tready = ~|(hit & full);
  assign drop_cnt = drop_q;
  assign ce = ce_q;
  // count beats with no matching channel, saturating at all-ones
  always_comb begin
    drop_d = (lii_in_p0_tvalid && !route_ok && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end
  // drop counter and clock enable; ce looks at next-cycle fullness so it drops with full
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      drop_q <= '0;
      ce_q   <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ce_q   <= ~|full_n;
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [LW-1:0] mem_q [DEPTH];
    logic [LW-1:0] head;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] lane_q, lane_d;
    logic          push, pop, fire;
    assign hit[c] = idx == 8'(c);
    assign head = mem_q[rd_q[AW-1:0]];
    assign full[c] = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign ch_tvalid[c] = wr_q != rd_q;
    assign ch_tdata[c*KW +: KW] = head[lane_q*KW +: KW];
    assign fire = ch_tvalid[c] & ch_tready[c];
    assign push = lii_in_p0_tvalid & hit[c] & !full[c];
    assign pop = fire & (lane_q == LAST);
    // pointer and lane advance; the beat is popped only after its last lane is taken
    always_comb begin
      wr_d = push ? wr_q + 1'b1 : wr_q;
      rd_d = pop ? rd_q + 1'b1 : rd_q;
      lane_d = !fire ? lane_q : (lane_q == LAST) ? '0 : lane_q + 1'b1;
      full_n[c] = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    end
    // FIFO pointers and lane counter
    always_ff @(posedge aclk) begin
      if (!arstn) begin
        wr_q   <= '0;
        rd_q   <= '0;
        lane_q <= '0;
      end else begin
        wr_q   <= wr_d;
        rd_q   <= rd_d;
        lane_q <= lane_d;
      end
    end
    // beat storage; contents are irrelevant while the pointers say empty
    always_ff @(posedge aclk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= lii_in_p0_tdata[LW-1:0];
    end
  end
endmodule

// File: tb/tb_lii_unpack_router.sv
// tb_lii_unpack_router: directed checks of routing, serialisation, drops, backpressure and reset
module tb_lii_unpack_router;
  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [63:0] a_td = '0, b_td = '0;
  logic        a_tv = 1'b0, b_tv = 1'b0;
  logic        a_tr, b_tr;
  logic [7:0]  a_dst = '0, b_dst = '0;
  logic [15:0] a_chd, b_chd;
  logic [1:0]  a_chv, b_chv;
  logic [1:0]  a_chr = 2'b11, b_chr = 2'b11;
  logic [15:0] a_drop, b_drop;
  logic        a_ce, b_ce;
  int          n_chk = 0, n_fail = 0;
  logic [7:0]  lanes_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [63:0] beats [3] = '{64'h44332211, 64'h88776655, 64'hCCBBAA99};
  always #5 clk = ~clk;
  lii_unpack_router #(.NCH(2), .PW(64), .KW(8), .LANES(1), .DEPTH(4), .BASE_DST(0)) d1 (
    .aclk(clk), .arstn(arstn), .lii_in_p0_tdata(a_td), .lii_in_p0_tvalid(a_tv),
    .lii_in_p0_tready(a_tr), .lii_in_p0_src(8'h3C), .lii_in_p0_dst(a_dst),
    .ch_tdata(a_chd), .ch_tvalid(a_chv), .ch_tready(a_chr), .drop_cnt(a_drop), .ce(a_ce));
  lii_unpack_router #(.NCH(2), .PW(64), .KW(8), .LANES(4), .DEPTH(4), .BASE_DST(0)) d4 (
    .aclk(clk), .arstn(arstn), .lii_in_p0_tdata(b_td), .lii_in_p0_tvalid(b_tv),
    .lii_in_p0_tready(b_tr), .lii_in_p0_src(8'h5A), .lii_in_p0_dst(b_dst),
    .ch_tdata(b_chd), .ch_tvalid(b_chv), .ch_tready(b_chr), .drop_cnt(b_drop), .ce(b_ce));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_a_chv", 64'(a_chv), 0);
    chk("rst_a_drop", 64'(a_drop), 0);
    chk("rst_a_ce", 64'(a_ce), 0);
    chk("rst_b_chv", 64'(b_chv), 0);
    arstn = 1'b1;
    #1;
    chk("ce_first", 64'(a_ce), 0);
    tick;
    chk("ce_second", 64'(a_ce), 1);
    a_dst = 8'd0;
    a_td = 64'h1234_5678_9ABC_DEA5;
    a_tv = 1'b1;
    #1;
    chk("t1_tready", 64'(a_tr), 1);
    tick;
    a_tv = 1'b0;
    chk("t1_chv", 64'(a_chv), 64'b01);
    chk("t1_chd", 64'(a_chd[7:0]), 64'hA5);
    tick;
    chk("t1_drained", 64'(a_chv), 0);
    b_dst = 8'd0;
    b_td = 64'h0000_0000_4433_2211;
    b_tv = 1'b1;
    tick;
    b_tv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_chv", 64'(b_chv), 64'b01);
      chk("t2_lane", 64'(b_chd[7:0]), 64'(lanes_exp[k]));
      tick;
    end
    chk("t2_done", 64'(b_chv), 0);
    a_dst = 8'd5;
    a_tv = 1'b1;
    #1;
    chk("t3_tready", 64'(a_tr), 1);
    tick;
    a_tv = 1'b0;
    chk("t3_nochan", 64'(a_chv), 0);
    chk("t3_drop1", 64'(a_drop), 1);
    a_dst = 8'd2;
    a_tv = 1'b1;
    tick;
    a_tv = 1'b0;
    chk("t3_drop2", 64'(a_drop), 2);
    d1.drop_q = 16'hFFFE;
    a_tv = 1'b1;
    tick;
    chk("t3_reach_max", 64'(a_drop), 64'hFFFF);
    tick;
    a_tv = 1'b0;
    chk("t3_saturate", 64'(a_drop), 64'hFFFF);
    a_chr = 2'b10;
    a_dst = 8'd0;
    for (int k = 0; k < 4; k++) begin
      a_td = 64'(k + 1);
      a_tv = 1'b1;
      tick;
    end
    a_tv = 1'b0;
    chk("t4_full_tready", 64'(a_tr), 0);
    chk("t4_full_ce", 64'(a_ce), 0);
    chk("t4_head_stable", 64'(a_chd[7:0]), 64'h01);
    a_dst = 8'd1;
    #1;
    chk("t4_ch1_tready", 64'(a_tr), 1);
    a_dst = 8'd0;
    a_td = 64'h5;
    a_tv = 1'b1;
    a_chr = 2'b11;
    tick;
    a_chr = 2'b10;
    #1;
    chk("t5_pop_tready", 64'(a_tr), 1);
    chk("t5_pop_ce", 64'(a_ce), 1);
    chk("t5_head", 64'(a_chd[7:0]), 64'h02);
    tick;
    a_tv = 1'b0;
    chk("t5_refull", 64'(a_tr), 0);
    a_chr = 2'b11;
    for (int k = 0; k < 4; k++) begin
      chk("t5_order_v", 64'(a_chv[0]), 1);
      chk("t5_order_d", 64'(a_chd[7:0]), 64'(k + 2));
      tick;
    end
    chk("t5_empty", 64'(a_chv), 0);
    b_chr = 2'b00;
    b_dst = 8'd0;
    for (int k = 0; k < 3; k++) begin
      b_td = beats[k];
      b_tv = 1'b1;
      tick;
    end
    b_tv = 1'b0;
    b_chr = 2'b01;
    tick;
    b_chr = 2'b00;
    chk("t6_midlane", 64'(b_chd[7:0]), 64'h22);
    b_dst = 8'd7;
    b_tv = 1'b1;
    tick;
    b_tv = 1'b0;
    chk("t6_drop_pre", 64'(b_drop), 1);
    arstn = 1'b0;
    tick;
    chk("t6_chv", 64'(b_chv), 0);
    chk("t6_drop", 64'(b_drop), 0);
    chk("t6_ce", 64'(b_ce), 0);
    chk("t6_a_drop", 64'(a_drop), 0);
    arstn = 1'b1;
    b_dst = 8'd0;
    b_td = 64'hD4C3B2A1;
    b_tv = 1'b1;
    b_chr = 2'b01;
    tick;
    b_tv = 1'b0;
    chk("t6_new_chv", 64'(b_chv), 64'b01);
    chk("t6_lane0", 64'(b_chd[7:0]), 64'hA1);
    tick;
    chk("t6_lane1", 64'(b_chd[7:0]), 64'hB2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
